cpu_control_sequencer: RTL and testbench
========================================

# cpu_control_sequencer

Multi-cycle control unit that drives the 4-bit CPU datapath: it generates the program-counter address and fetches three 4-bit nibbles per instruction from the asynchronous instruction memory. It decodes each instruction and produces one execute cycle of register-file and ALU control: read/write addresses, ALU function, write-data mux select, external immediate and write enable. It replaces the hand-driven control inputs of the datapath so a stored program runs autonomously.

## Interface
Parameters:
- none (datapath widths fixed: 4-bit data, 4-bit address, 2-bit register address, 2-bit ALU function)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- start  in  1  begin execution; honoured only in IDLE
- instruction  in  4  nibble read from instruction memory at address (combinational memory)
- address  out  4  nibble fetch address (PC), registered
- readAddr1  out  2  ALU operand A register
- readAddr2  out  2  ALU operand B register
- writeAddr  out  2  destination register
- aluFunc  out  2  ALU function code
- muxSelect  out  1  1 = write ALU result, 0 = write exWriteData
- exWriteData  out  4  immediate for LOADI
- regWrite  out  1  register-file write enable, one-cycle pulse
- busy  out  1  high in FETCH0/FETCH1/FETCH2/EXEC (and PAUSE if compiled in)
- halted  out  1  high in HALTED
- step  in  1  only present with CTRL_STEP_EN

## Operation
- Instruction = three consecutive nibbles n0,n1,n2 at address, address+1, address+2.
  - n0 = {cls[1:0], func[1:0]}; n1 = {dst[1:0], srcA[1:0]}; n2 = {srcB[1:0], 2'b00} for ALU, or imm[3:0] for LOADI.
  - cls 00 ALU: readAddr1=srcA, readAddr2=srcB, writeAddr=dst, aluFunc=func, muxSelect=1, regWrite=1.
  - cls 01 LOADI: writeAddr=dst, exWriteData=imm, muxSelect=0, regWrite=1.
  - cls 10 NOP: regWrite=0.
  - cls 11 HALT: regWrite=0, then HALTED.
- States: IDLE, FETCH0, FETCH1, FETCH2, EXEC, HALTED.
  - IDLE -> FETCH0 when start=1; otherwise stay.
  - FETCHk: latch instruction into nibble register k; address <= address+1; -> next fetch state, or EXEC after FETCH2.
  - EXEC: decoded control outputs valid. HALT instruction -> HALTED; any other class -> FETCH0.
  - HALTED: sticky until reset; start is ignored.
- address is 4-bit and wraps 15 -> 0. An instruction straddling the wrap is fetched normally from 15, 0, 1.
- start is ignored in every state except IDLE.
- Outside EXEC: regWrite=0. readAddr1, readAddr2, writeAddr, aluFunc, muxSelect and exWriteData hold their last EXEC values.

## Timing
- Reset values: state IDLE, address 0, all nibble registers 0, every output 0 (busy 0, halted 0, regWrite 0).
- Reset at any cycle, including mid-instruction, returns to IDLE on the next edge; a partially fetched instruction is discarded and no write occurs.
- Latency: start sampled at edge T0 -> FETCH0 during cycle 1, FETCH1 cycle 2, FETCH2 cycle 3, EXEC cycle 4. Steady state is 4 cycles per instruction.
- Control outputs are registered and become valid at the edge entering EXEC. The register file captures the write at the edge leaving EXEC.
- halted rises at the edge leaving a HALT EXEC; busy falls on the same edge.

## Configuration
- CTRL_STEP_EN defined:
  - adds the step input and a PAUSE state;
  - EXEC of a non-HALT instruction -> PAUSE; PAUSE -> FETCH0 when step=1; busy stays 1 in PAUSE;
  - step is ignored in all other states; a step and reset in the same cycle resolve to reset.
- CTRL_STEP_EN undefined: no step port, no PAUSE state; EXEC -> FETCH0 directly.

## Test plan
- Reset: assert reset 2 cycles -> address=0, regWrite=0, busy=0, halted=0, all control outputs 0. Drive start=1 while reset=1 -> still IDLE.
- LOADI: memory {0100,0100,1010}, pulse start -> in cycle 4 writeAddr=1, muxSelect=0, exWriteData=1010, regWrite=1; regWrite=0 in cycles 1–3 and 5.
- ALU: memory {0010,1001,1100} -> in EXEC readAddr1=1, readAddr2=3, writeAddr=2, aluFunc=2, muxSelect=1, regWrite=1.
- HALT + wrap: five NOPs (1000,0000,0000 ×5) followed by HALT at nibbles 15,0,1 -> address sequence 15→0→1. halted=1 after that EXEC; a later start causes no change.
- Reset mid-instruction: assert reset during FETCH1 -> next cycle IDLE, address=0, no regWrite pulse. A subsequent start refetches from address 0.
- With CTRL_STEP_EN: two LOADI instructions -> after the first EXEC the unit holds in PAUSE with address=3 and busy=1. Step pulse -> second instruction reaches EXEC 4 cycles later.

Source files
------------

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute control unit for the 4-bit CPU datapath.
// Optional single-step mode (PAUSE state, step input) is enabled by defining CTRL_STEP_EN.
module cpu_control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] instruction,
`ifdef CTRL_STEP_EN
  input  logic       step,
`endif
  output logic [3:0] address,
  output logic [1:0] readAddr1,
  output logic [1:0] readAddr2,
  output logic [1:0] writeAddr,
  output logic [1:0] aluFunc,
  output logic       muxSelect,
  output logic [3:0] exWriteData,
  output logic       regWrite,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_EXEC, S_HALTED, S_PAUSE
  } state_t;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOADI = 2'b01;
  localparam logic [1:0] CLS_HALT  = 2'b11;

  state_t     state, next_state;
  logic [3:0] n0, n1;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_FETCH0;
      S_FETCH0: next_state = S_FETCH1;
      S_FETCH1: next_state = S_FETCH2;
      S_FETCH2: next_state = S_EXEC;
      S_EXEC: begin
        if (n0[3:2] == CLS_HALT) next_state = S_HALTED;
`ifdef CTRL_STEP_EN
        else                     next_state = S_PAUSE;
`else
        else                     next_state = S_FETCH0;
`endif
      end
`ifdef CTRL_STEP_EN
      S_PAUSE:  if (step) next_state = S_FETCH0;
`endif
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      address     <= '0;
      n0          <= '0;
      n1          <= '0;
      readAddr1   <= '0;
      readAddr2   <= '0;
      writeAddr   <= '0;
      aluFunc     <= '0;
      muxSelect   <= 1'b0;
      exWriteData <= '0;
      regWrite    <= 1'b0;
    end else begin
      state    <= next_state;
      regWrite <= 1'b0;
      case (state)
        S_FETCH0: begin
          n0      <= instruction;
          address <= address + 4'd1;
        end
        S_FETCH1: begin
          n1      <= instruction;
          address <= address + 4'd1;
        end
        S_FETCH2: begin
          // Third nibble is decoded straight off the bus so controls are valid on entering EXEC.
          address <= address + 4'd1;
          case (n0[3:2])
            CLS_ALU: begin
              readAddr1 <= n1[1:0];
              readAddr2 <= instruction[3:2];
              writeAddr <= n1[3:2];
              aluFunc   <= n0[1:0];
              muxSelect <= 1'b1;
              regWrite  <= 1'b1;
            end
            CLS_LOADI: begin
              writeAddr   <= n1[3:2];
              exWriteData <= instruction;
              muxSelect   <= 1'b0;
              regWrite    <= 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (state == S_FETCH0) || (state == S_FETCH1) || (state == S_FETCH2) ||
             (state == S_EXEC)   || (state == S_PAUSE);
    halted = (state == S_HALTED);
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer: directed scenarios plus random programs
// checked against an instruction-level reference model of the fetch/execute sequence.
module tb_cpu_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, step;
  logic [3:0] instruction, address, exWriteData;
  logic [1:0] readAddr1, readAddr2, writeAddr, aluFunc;
  logic       muxSelect, regWrite, busy, halted;

  logic [3:0] mem [16];
  logic [3:0] pc;
  int         n_checks = 0;
  int         n_fail   = 0;

  assign instruction = mem[address];

  cpu_control_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instruction(instruction),
`ifdef CTRL_STEP_EN
    .step(step),
`endif
    .address(address), .readAddr1(readAddr1), .readAddr2(readAddr2),
    .writeAddr(writeAddr), .aluFunc(aluFunc), .muxSelect(muxSelect),
    .exWriteData(exWriteData), .regWrite(regWrite), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; step = 1'b0;
    tick(); tick();
    reset = 1'b0;
    pc = 4'd0;
  endtask

  task automatic check_idle(input string tag, input logic [3:0] exp_addr);
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_halted"}, 8'(halted), 8'd0);
    check({tag, "_regwrite"}, 8'(regWrite), 8'd0);
    check({tag, "_addr"}, 8'(address), 8'(exp_addr));
  endtask

  task automatic check_reset_outputs();
    check("rst_ra1", 8'(readAddr1), 8'd0);
    check("rst_ra2", 8'(readAddr2), 8'd0);
    check("rst_wa", 8'(writeAddr), 8'd0);
    check("rst_func", 8'(aluFunc), 8'd0);
    check("rst_mux", 8'(muxSelect), 8'd0);
    check("rst_imm", 8'(exWriteData), 8'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Reference model: one instruction = three fetch cycles at pc, pc+1, pc+2, then one EXEC cycle
  // whose controls follow from the three nibbles. Entered while the DUT is in its first fetch cycle.
  task automatic run_instr(output logic was_halt);
    logic [3:0] a, b, c, ea;
    a = mem[pc]; b = mem[pc + 4'd1]; c = mem[pc + 4'd2];
    for (int k = 0; k < 3; k++) begin
      ea = pc + 4'(k);
      check("fetch_addr", 8'(address), 8'(ea));
      check("fetch_busy", 8'(busy), 8'd1);
      check("fetch_regwrite", 8'(regWrite), 8'd0);
      tick();
    end
    check("exec_busy", 8'(busy), 8'd1);
    check("exec_regwrite", 8'(regWrite), 8'(a[3:2] == 2'b00 || a[3:2] == 2'b01));
    if (a[3:2] == 2'b00) begin
      check("alu_ra1", 8'(readAddr1), 8'(b[1:0]));
      check("alu_ra2", 8'(readAddr2), 8'(c[3:2]));
      check("alu_wa", 8'(writeAddr), 8'(b[3:2]));
      check("alu_func", 8'(aluFunc), 8'(a[1:0]));
      check("alu_mux", 8'(muxSelect), 8'd1);
    end else if (a[3:2] == 2'b01) begin
      check("ldi_wa", 8'(writeAddr), 8'(b[3:2]));
      check("ldi_imm", 8'(exWriteData), 8'(c));
      check("ldi_mux", 8'(muxSelect), 8'd0);
    end
    tick();
    pc = pc + 4'd3;
    was_halt = (a[3:2] == 2'b11);
    if (was_halt) begin
      check("halt_halted", 8'(halted), 8'd1);
      check("halt_busy", 8'(busy), 8'd0);
      check("halt_regwrite", 8'(regWrite), 8'd0);
    end else begin
`ifdef CTRL_STEP_EN
      for (int k = 0; k < 2; k++) begin
        check("pause_busy", 8'(busy), 8'd1);
        check("pause_addr", 8'(address), 8'(pc));
        check("pause_regwrite", 8'(regWrite), 8'd0);
        tick();
      end
      step = 1'b1; tick(); step = 1'b0;
`endif
    end
  endtask

  initial begin
    logic h;

    // Reset, including start held during reset
    reset = 1'b1; start = 1'b1; step = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 4'b1000;
    tick(); tick();
    check_idle("reset", 4'd0);
    check_reset_outputs();
    reset = 1'b0; start = 1'b0; pc = 4'd0;
    tick();
    check_idle("reset_hold", 4'd0);

    // LOADI r1 <- 1010
    mem[0] = 4'b0100; mem[1] = 4'b0100; mem[2] = 4'b1010;
    pulse_start();
    run_instr(h);

    // ALU r2 <- r1 func2 r3
    do_reset();
    mem[0] = 4'b0010; mem[1] = 4'b1001; mem[2] = 4'b1100;
    pulse_start();
    run_instr(h);

    // Five NOPs then HALT straddling the 15 -> 0 wrap
    do_reset();
    for (int i = 0; i < 15; i++) mem[i] = (i % 3 == 0) ? 4'b1000 : 4'b0000;
    mem[15] = 4'b1100;
    pulse_start();
    h = 1'b0;
    for (int i = 0; i < 6 && !h; i++) run_instr(h);
    check("wrap_halted_seen", 8'(h), 8'd1);
    check("wrap_addr", 8'(address), 8'd2);
    start = 1'b1; tick(); tick(); start = 1'b0; tick();
    check("halt_sticky_halted", 8'(halted), 8'd1);
    check("halt_sticky_busy", 8'(busy), 8'd0);
    check("halt_sticky_addr", 8'(address), 8'd2);

    // Reset during FETCH1 of a LOADI discards it
    do_reset();
    mem[0] = 4'b0111; mem[1] = 4'b1100; mem[2] = 4'b0101;
    pulse_start();
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_idle("midrst", 4'd0);
    check_reset_outputs();
    tick();
    check_idle("midrst_after", 4'd0);
    pc = 4'd0;
    pulse_start();
    run_instr(h);

    // Random programs
    for (int p = 0; p < 10; p++) begin
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
      pulse_start();
      h = 1'b0;
      for (int i = 0; i < 7 && !h; i++) run_instr(h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
